// File: rtl/minv_pkg.sv
// Shared definitions for the modular-inverse X register sequencer:
// opcodes, FSM state encoding and default geometry of the register.
package minv_pkg;

  localparam int NWORDS_DEF = 16;
  localparam int WW_DEF     = 16;
  localparam int CNTW_DEF   = 8;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_READ = 3'd2;
  localparam logic [2:0] OP_SHR  = 3'd3;
  localparam logic [2:0] OP_SET1 = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_READ  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_SET   = 3'd4
  } state_t;

endpackage

// File: rtl/minv_x1_seq.sv
// Sequencer for the 256-bit X register (ring of word slices). Expands a
// single command into the exact cycle sequence of shared slice controls:
// word-serial load, non-destructive rotate readout, n-bit right shift and
// set-to-one. done/err are registered; all other outputs are decoded
// combinationally from the state and the live handshakes.
module minv_x1_seq
  import minv_pkg::*;
#(
  parameter int NWORDS = NWORDS_DEF,
  parameter int WW     = WW_DEF,
  parameter int CNTW   = CNTW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_op,
  input  logic [CNTW-1:0] cmd_cnt,
  input  logic            fill_in,
  input  logic [WW-1:0]   din,
  input  logic            din_valid,
  output logic            din_ready,
  output logic [WW-1:0]   dout,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic            done,
  output logic            err,
  output logic            busy,
  output logic            reg_we,
  output logic            reg_sel_cyc,
  output logic            reg_sel_rs,
  output logic            reg_set,
  output logic [WW-1:0]   reg_regin,
  output logic            reg_bit256,
  input  logic [WW-1:0]   reg_regout
);

  // word_cnt is 4 bits wide; the last beat is the one at NWORDS-1
  localparam logic [3:0] LAST_WORD = 4'(NWORDS - 1);

  state_t            state_r, state_s;
  logic [3:0]        word_cnt_r, word_cnt_s;
  logic [CNTW-1:0]   shift_cnt_r, shift_cnt_s;
  logic              done_r, done_s;
  logic              err_r, err_s;

  assign done = done_r;
  assign err  = err_r;
  assign busy = (state_r != ST_IDLE);
  assign dout = reg_regout;

  // State, counters and completion flags; synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      word_cnt_r  <= 4'd0;
      shift_cnt_r <= {CNTW{1'b0}};
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      word_cnt_r  <= word_cnt_s;
      shift_cnt_r <= shift_cnt_s;
      done_r      <= done_s;
      err_r       <= err_s;
    end
  end

  // Next-state, counter updates and register-control decode
  always_comb begin
    state_s     = state_r;
    word_cnt_s  = word_cnt_r;
    shift_cnt_s = shift_cnt_r;
    done_s      = 1'b0;
    err_s       = 1'b0;
    cmd_ready   = 1'b0;
    din_ready   = 1'b0;
    dout_valid  = 1'b0;
    reg_we      = 1'b0;
    reg_sel_cyc = 1'b0;
    reg_sel_rs  = 1'b0;
    reg_set     = 1'b0;
    reg_regin   = {WW{1'b0}};
    reg_bit256  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (cmd_op)
            OP_NOP: begin
              done_s = 1'b1;
            end
            OP_LOAD: begin
              state_s    = ST_LOAD;
              word_cnt_s = 4'd0;
            end
            OP_READ: begin
              state_s    = ST_READ;
              word_cnt_s = 4'd0;
            end
            OP_SHR: begin
              // a zero-length shift completes immediately without touching the register
              if (cmd_cnt != {CNTW{1'b0}}) begin
                state_s     = ST_SHIFT;
                shift_cnt_s = cmd_cnt;
              end else begin
                done_s = 1'b1;
              end
            end
            OP_SET1: begin
              state_s = ST_SET;
            end
            default: begin
              done_s = 1'b1;
              err_s  = 1'b1;
            end
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_LOAD: begin
        din_ready = 1'b1;
        reg_regin = din;
        if (din_valid) begin
          reg_we = 1'b1;
          if (word_cnt_r == LAST_WORD) begin
            word_cnt_s = 4'd0;
            state_s    = ST_IDLE;
            done_s     = 1'b1;
          end else begin
            word_cnt_s = word_cnt_r + 4'd1;
          end
        end else begin
          reg_we = 1'b0;
        end
      end

      ST_READ: begin
        // readout rotates the ring, so after NWORDS beats the content is restored
        dout_valid = 1'b1;
        if (dout_ready) begin
          reg_we      = 1'b1;
          reg_sel_cyc = 1'b1;
          if (word_cnt_r == LAST_WORD) begin
            word_cnt_s = 4'd0;
            state_s    = ST_IDLE;
            done_s     = 1'b1;
          end else begin
            word_cnt_s = word_cnt_r + 4'd1;
          end
        end else begin
          reg_we = 1'b0;
        end
      end

      ST_SHIFT: begin
        // fill_in is the live adder carry, so it is passed through every cycle
        reg_we      = 1'b1;
        reg_sel_rs  = 1'b1;
        reg_bit256  = fill_in;
        shift_cnt_s = shift_cnt_r - CNTW'(1);
        if (shift_cnt_r == CNTW'(1)) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = ST_SHIFT;
        end
      end

      ST_SET: begin
        reg_we  = 1'b1;
        reg_set = 1'b1;
        state_s = ST_IDLE;
        done_s  = 1'b1;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_minv_x1_seq.sv
// Directed bench for minv_x1_seq with a behavioural 16 x 16-bit register ring.
module tb_minv_x1_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_cnt;
  logic        fill_in;
  logic [15:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        done;
  logic        err;
  logic        busy;
  logic        reg_we;
  logic        reg_sel_cyc;
  logic        reg_sel_rs;
  logic        reg_set;
  logic [15:0] reg_regin;
  logic        reg_bit256;
  logic [15:0] reg_regout;

  logic [255:0] reg_q = 256'd0;
  int we_n = 0, cyc_n = 0, rs_n = 0, done_n = 0, ready_bad = 0, excl_bad = 0;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  minv_x1_seq dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_cnt(cmd_cnt),
    .fill_in(fill_in),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .done(done), .err(err), .busy(busy),
    .reg_we(reg_we), .reg_sel_cyc(reg_sel_cyc), .reg_sel_rs(reg_sel_rs), .reg_set(reg_set),
    .reg_regin(reg_regin), .reg_bit256(reg_bit256), .reg_regout(reg_regout)
  );

  assign reg_regout = reg_q[15:0];

  // Behavioural register ring plus event counters
  always @(posedge clk) begin
    if (reg_we) begin
      we_n <= we_n + 1;
      if (reg_set)          reg_q <= 256'd1;
      else if (reg_sel_rs)  reg_q <= {reg_bit256, reg_q[255:1]};
      else if (reg_sel_cyc) reg_q <= {reg_q[15:0], reg_q[255:16]};
      else                  reg_q <= {reg_regin, reg_q[255:16]};
      if (reg_sel_cyc) cyc_n <= cyc_n + 1;
      if (reg_sel_rs)  rs_n  <= rs_n + 1;
      if ((32'(reg_sel_cyc) + 32'(reg_sel_rs) + 32'(reg_set)) > 32'd1) excl_bad <= excl_bad + 1;
    end
    if (done) done_n <= done_n + 1;
    if (cmd_ready && busy) ready_bad <= ready_bad + 1;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one command at a negedge while the DUT is idle; returns one cycle later
  task automatic issue(input logic [2:0] op, input logic [7:0] cnt);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cnt   = cnt;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_cnt   = 8'd0;
  endtask

  task automatic load_words(input logic [255:0] data, input int stall_a, input int stall_b);
    issue(3'd1, 8'd0);
    chk("load_din_ready", din_ready, 1);
    for (int i = 0; i < 16; i++) begin
      if ((i + 1 == stall_a) || (i + 1 == stall_b)) begin
        din_valid = 1'b0;
        @(negedge clk);
      end
      din       = data[16*i +: 16];
      din_valid = 1'b1;
      @(negedge clk);
    end
    din_valid = 1'b0;
  endtask

  task automatic read_words(input logic [255:0] exp, input bit toggle);
    int got = 0;
    int cyc = 0;
    bit tog = 1'b1;
    issue(3'd2, 8'd0);
    while (got < 16 && cyc < 100) begin
      dout_ready = toggle ? tog : 1'b1;
      tog = ~tog;
      #1;
      if (dout_valid && dout_ready) begin
        chk($sformatf("read_word%0d", got), dout, exp[16*got +: 16]);
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    dout_ready = 1'b0;
    chk("read_beats", got, 16);
  endtask

  initial begin
    logic [255:0] e1, e3, e5, e;
    int s_we, s_cyc, s_rs, s_done;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_cnt = 8'd0; fill_in = 1'b0;
    din = 16'd0; din_valid = 1'b0; dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_we", reg_we, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_dout_valid", dout_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // LOAD 0x0001..0x0010 with gaps before beats 3 and 9
    for (int i = 0; i < 16; i++) e1[16*i +: 16] = 16'(i + 1);
    s_we = we_n; s_cyc = cyc_n; s_done = done_n;
    load_words(e1, 3, 9);
    chk("load_done", done, 1);
    chk("load_we_count", we_n - s_we, 16);
    chk("load_cyc_count", cyc_n - s_cyc, 0);
    chk("load_reg", reg_q, e1);
    @(negedge clk);
    chk("load_done_pulse", done, 0);
    chk("load_done_count", done_n - s_done, 1);

    // READ with dout_ready toggling; register restored
    s_cyc = cyc_n; s_done = done_n;
    read_words(e1, 1'b1);
    chk("read_done", done, 1);
    @(negedge clk);
    chk("read_done_count", done_n - s_done, 1);
    chk("read_cyc_count", cyc_n - s_cyc, 16);
    chk("read_reg_kept", reg_q, e1);

    // SHR 3 on value 8 with fill 1,0,1
    e3 = 256'd0; e3[15:0] = 16'h0008;
    load_words(e3, 0, 0);
    @(negedge clk);
    s_we = we_n; s_rs = rs_n;
    issue(3'd3, 8'd3);
    fill_in = 1'b1; @(negedge clk);
    fill_in = 1'b0; @(negedge clk);
    fill_in = 1'b1; @(negedge clk);
    fill_in = 1'b0;
    chk("shr3_done", done, 1);
    chk("shr3_rs_count", rs_n - s_rs, 3);
    chk("shr3_we_count", we_n - s_we, 3);
    e = 256'd0; e[255:240] = 16'hA000; e[15:0] = 16'h0001;
    chk("shr3_reg", reg_q, e);
    @(negedge clk);

    // SHR 0: no write, immediate done
    s_we = we_n;
    issue(3'd3, 8'd0);
    chk("shr0_done", done, 1);
    chk("shr0_busy", busy, 0);
    chk("shr0_we_count", we_n - s_we, 0);
    @(negedge clk);

    // SET1 then READ
    issue(3'd4, 8'd0);
    chk("set_busy", busy, 1);
    @(negedge clk);
    chk("set_done", done, 1);
    chk("set_reg", reg_q, 256'd1);
    @(negedge clk);
    read_words(256'd1, 1'b0);
    @(negedge clk);

    // illegal opcode 6
    s_we = we_n;
    issue(3'd6, 8'd0);
    chk("ill_done", done, 1);
    chk("ill_err", err, 1);
    chk("ill_we_count", we_n - s_we, 0);
    @(negedge clk);
    chk("ill_err_pulse", err, 0);

    // reset on LOAD beat 7
    s_done = done_n;
    issue(3'd1, 8'd0);
    for (int i = 1; i <= 6; i++) begin
      din = 16'(i); din_valid = 1'b1; @(negedge clk);
    end
    din = 16'd7; din_valid = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_we", reg_we, 0);
    chk("rstmid_done", done, 0);
    rst_n = 1'b1; din_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_no_done", done_n - s_done, 0);
    for (int i = 0; i < 16; i++) e5[16*i +: 16] = 16'h1000 + 16'(i);
    s_we = we_n;
    load_words(e5, 0, 0);
    chk("reload_done", done, 1);
    chk("reload_we_count", we_n - s_we, 16);
    chk("reload_reg", reg_q, e5);
    @(negedge clk);

    // back-to-back SET1 then SHR 1 with cmd_valid held
    s_rs = rs_n;
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_cnt = 8'd0;
    @(negedge clk);
    chk("b2b_ready_in_set", cmd_ready, 0);
    cmd_op = 3'd3; cmd_cnt = 8'd1; fill_in = 1'b1;
    @(negedge clk);
    chk("b2b_done1", done, 1);
    chk("b2b_ready1", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_cnt = 8'd0;
    chk("b2b_busy", busy, 1);
    chk("b2b_ready_in_shift", cmd_ready, 0);
    @(negedge clk);
    fill_in = 1'b0;
    chk("b2b_done2", done, 1);
    chk("b2b_rs_count", rs_n - s_rs, 1);
    e = 256'd0; e[255] = 1'b1;
    chk("b2b_reg", reg_q, e);
    @(negedge clk);

    chk("ready_outside_idle", ready_bad, 0);
    chk("ctrl_exclusive", excl_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so a stuck DUT cannot hang the run
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/minv_x1_seq.md
Name: minv_x1_seq

Overview:
- Sequencer for the 256-bit modular-inverse X register. The register is a ring of 16 × 16-bit slices; this block drives each slice's shared controls: reg_we, reg_sel_cyc, reg_sel_rs, reg_set and reg_bit256.
- Turns single commands into exact cycle sequences:
  - LOAD: word-serial load.
  - READ: non-destructive word-serial readout.
  - SHR: n-bit right shift.
  - SET1: set register to 1.
- Sits between the inversion-algorithm FSM and the register bank.

Parameters:
- NWORDS, 16, number of 16-bit slices in the register.
- WW, 16, word width.
- CNTW, 8, width of the shift-count argument.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  3  opcode: 0 NOP, 1 LOAD, 2 READ, 3 SHR, 4 SET1, 5–7 illegal.
- cmd_cnt  in  CNTW  shift count for SHR; ignored for other opcodes.
- fill_in  in  1  MSB fill bit during SHR; sampled live each shift cycle (carry from the external adder).
- din  in  WW  load word, least-significant word first.
- din_valid  in  1  load word valid.
- din_ready  out  1  high in LOAD.
- dout  out  WW  read word; equals reg_regout.
- dout_valid  out  1  high in READ.
- dout_ready  in  1  consumer accepts the read word.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  one-cycle pulse with done for an illegal opcode.
- busy  out  1  state != IDLE.
- reg_we, reg_sel_cyc, reg_sel_rs, reg_set  out  1 each  register controls.
- reg_regin  out  WW  word fed to the top slice; equals din.
- reg_bit256  out  1  MSB fill bit.
- reg_regout  in  WW  least-significant slice output.

Behaviour:
- Register semantics the controls must produce:
  - we=0: hold.
  - we=1, sel_cyc=0, sel_rs=0: word shift right, regin enters the top slice.
  - we=1, sel_cyc=1, sel_rs=0: rotate right one word.
  - we=1, sel_rs=1: shift right 1 bit, bit256 enters bit 255.
  - set=1 with we=1: register := 1.
- Output timing:
  - reg_* and din_ready/dout_valid are combinational from state and the handshakes.
  - done and err are registered.
  - At most one of sel_cyc, sel_rs, set is high while we=1. All reg_* outputs are 0 in IDLE.
- Reset: rst_n low at a clock edge forces IDLE and clears word_cnt and shift_cnt. done, err and busy become 0, and all reg_* outputs become 0 in the same cycle. This applies mid-command too; the partial register content is abandoned.
- States: IDLE, LOAD, READ, SHIFT, SET.
- IDLE: a command is accepted when cmd_valid && cmd_ready. Next state:
  - LOAD, READ, SET for opcodes 1, 2, 4.
  - SHIFT for opcode 3 with cmd_cnt != 0.
  - Stay in IDLE for NOP, for SHR with cmd_cnt = 0, and for illegal opcodes. done pulses the next cycle; err also pulses for an illegal opcode.
- LOAD: din_ready=1.
  - Each beat (din_valid=1): reg_we=1, sel_cyc=0, word_cnt++.
  - No beat: reg_we=0.
  - On beat 16: go to IDLE; done pulses in the next cycle.
  - Result: the first word lands in slice 0 (LS).
- READ: dout_valid=1, dout=reg_regout.
  - Each beat (dout_ready=1): reg_we=1, sel_cyc=1 (rotate).
  - After 16 beats the register is restored; go to IDLE and pulse done.
  - Words are emitted LS first.
- SHIFT: shift_cnt is loaded with cmd_cnt at accept.
  - Each cycle: reg_we=1, sel_rs=1, reg_bit256=fill_in, shift_cnt--.
  - Exactly cmd_cnt consecutive cycles with no stalls, then IDLE plus done.
  - reg_bit256=0 outside SHIFT.
- SET: one cycle with reg_we=1, reg_set=1, then IDLE plus done.
- Throughput:
  - done and cmd_ready are high together in the first IDLE cycle, so back-to-back commands lose one cycle.
  - Latency from accept to done: LOAD/READ = 16 beats + 1; SHR n = n + 1; SET1 = 2.
- Counters:
  - word_cnt is 4 bits and compares against NWORDS-1. It wraps to 0 at exit and never exceeds 15.
  - shift_cnt is CNTW bits; max shift 255.

Decomposition:
- Shared package minv_pkg holds:
  - Opcode localparams OP_NOP..OP_SET1.
  - State encoding for IDLE/LOAD/READ/SHIFT/SET.
  - NWORDS and WW defaults.
- No sub-module is natural: the block is a single FSM with two counters, kept flat. The bench instantiates it with a 16-slice behavioural register model.

Test Plan:
- LOAD 16 words 0x0001..0x0010 with din_valid low on beats 3 and 9 -> exactly 16 we pulses with sel_cyc=0; register = 0x0010_000F_…_0001; done pulses one cycle after the last beat.
- READ after that LOAD, dout_ready toggling 1/0 -> dout sequence 0x0001..0x0010; register unchanged afterwards; done exactly once.
- SHR cmd_cnt=3 on 0x…0008 with fill_in=1,0,1 -> register = 1 followed by bits …; exactly 3 sel_rs cycles; done at cycle 4. SHR cmd_cnt=0 -> no we, done next cycle.
- SET1 then READ -> dout = 0x0001 then 15 × 0x0000; illegal opcode 6 -> done and err pulse together, no reg_we.
- rst_n low on LOAD beat 7 -> next cycle IDLE, busy=0, reg_we=0, no done; a new LOAD then completes after a full 16 beats.
- Back-to-back SET1 then SHR 1, cmd_valid held high -> second command accepted in the cycle done is high; cmd_ready never high outside IDLE.
